// File: rtl/regfile_wr_arbiter_if.sv
// Request/write-port bundle shared by the writeback sources and the
// register-file write arbiter. Source i occupies slice i of each packed vector.
interface regfile_wr_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_rd;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               RegWrite;
   logic [AW-1:0]      rd;
   logic [DW-1:0]      wr_data;
   logic [2:0]         grant_id;
   logic               starve_ovr;

   // Requester side: drives requests, observes grant and the write port
   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, RegWrite, rd, wr_data, grant_id, starve_ovr
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, RegWrite, rd, wr_data, grant_id, starve_ovr
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Source 0 (core writeback) has fixed
// priority; sources 1..NREQ-1 share round-robin and may override source 0
// once they have waited STARVE_LIM cycles. The accepted write is registered,
// so the register file sees it one cycle after the handshake. Writes to x0
// are accepted but never raise RegWrite.
module regfile_wr_arbiter #(
   parameter int NREQ       = 3,
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4
) (
   input logic                clk,
   input logic                rst,
   regfile_wr_arbiter_if.slave bus
);
   localparam logic [3:0] LIM  = 4'(STARVE_LIM);
   localparam logic [2:0] LAST = 3'(NREQ - 1);

   logic [2:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]    wait_cnt_q [NREQ];
   logic [3:0]    wait_cnt_d [NREQ];
   logic          regwrite_q, regwrite_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic [2:0]    grant_id_q, grant_id_d;
   logic          starve_ovr_q, starve_ovr_d;

   logic [7:0]    vld_x;
   logic [7:0]    starved;
   logic [2:0]    slot;
   logic          st_found, st_hit, v_found, v_hit;
   logic [2:0]    st_idx, v_idx;
   logic          grant_vld, grant_starved;
   logic [2:0]    grant_idx;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;

   // k-th position in round-robin order starting at ptr, over 1..NREQ-1
   function automatic logic [2:0] rr_slot(input logic [2:0] ptr, input int k);
      int t;
      t = int'(ptr) + k;
      return (t >= NREQ) ? 3'(t - (NREQ - 1)) : 3'(t);
   endfunction

   // Pick the winner: starved low-priority source, else source 0, else round-robin
   always_comb begin
      vld_x    = 8'(bus.req_valid);
      starved  = 8'd0;
      slot     = 3'd1;
      st_found = 1'b0;
      st_hit   = 1'b0;
      st_idx   = 3'd0;
      v_found  = 1'b0;
      v_hit    = 1'b0;
      v_idx    = 3'd0;
      for (int i = 1; i < NREQ; i++) begin
         starved[i] = vld_x[i] && (wait_cnt_q[i] == LIM);
      end
      for (int k = 0; k < NREQ - 1; k++) begin
         slot     = rr_slot(rr_ptr_q, k);
         st_hit   = !st_found && starved[slot];
         st_idx   = st_hit ? slot : st_idx;
         st_found = st_found | st_hit;
         v_hit    = !v_found && vld_x[slot];
         v_idx    = v_hit ? slot : v_idx;
         v_found  = v_found | v_hit;
      end
      if (rst) begin
         grant_vld     = 1'b0;
         grant_idx     = 3'd0;
         grant_starved = 1'b0;
      end else if (st_found) begin
         grant_vld     = 1'b1;
         grant_idx     = st_idx;
         grant_starved = 1'b1;
      end else if (vld_x[0]) begin
         grant_vld     = 1'b1;
         grant_idx     = 3'd0;
         grant_starved = 1'b0;
      end else if (v_found) begin
         grant_vld     = 1'b1;
         grant_idx     = v_idx;
         grant_starved = 1'b0;
      end else begin
         grant_vld     = 1'b0;
         grant_idx     = 3'd0;
         grant_starved = 1'b0;
      end
      bus.req_ready = grant_vld ? (NREQ'(1) << grant_idx) : '0;
      sel_rd        = bus.req_rd[int'(grant_idx) * AW +: AW];
      sel_data      = bus.req_data[int'(grant_idx) * DW +: DW];
   end

   // Next state: pointer advance, wait counters and the registered write port
   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      wait_cnt_d[0] = 4'd0;
      for (int i = 1; i < NREQ; i++) begin
         if (vld_x[i] && !(grant_vld && (grant_idx == 3'(i)))) begin
            wait_cnt_d[i] = (wait_cnt_q[i] >= LIM) ? LIM : wait_cnt_q[i] + 4'd1;
         end else begin
            wait_cnt_d[i] = 4'd0;
         end
      end
      if (grant_vld && (grant_idx != 3'd0)) begin
         if (grant_idx == LAST) begin
            rr_ptr_d = 3'd1;
         end else begin
            rr_ptr_d = grant_idx + 3'd1;
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      if (grant_vld) begin
         regwrite_d   = (sel_rd != {AW{1'b0}});
         rd_d         = sel_rd;
         wr_data_d    = sel_data;
         grant_id_d   = grant_idx;
         starve_ovr_d = grant_starved & vld_x[0];
      end else begin
         regwrite_d   = 1'b0;
         rd_d         = rd_q;
         wr_data_d    = wr_data_q;
         grant_id_d   = grant_id_q;
         starve_ovr_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= 3'd1;
         regwrite_q   <= 1'b0;
         rd_q         <= {AW{1'b0}};
         wr_data_q    <= {DW{1'b0}};
         grant_id_q   <= 3'd0;
         starve_ovr_q <= 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            wait_cnt_q[i] <= 4'd0;
         end
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         regwrite_q   <= regwrite_d;
         rd_q         <= rd_d;
         wr_data_q    <= wr_data_d;
         grant_id_q   <= grant_id_d;
         starve_ovr_q <= starve_ovr_d;
         for (int i = 0; i < NREQ; i++) begin
            wait_cnt_q[i] <= wait_cnt_d[i];
         end
      end
   end

   assign bus.RegWrite   = regwrite_q;
   assign bus.rd         = rd_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.grant_id   = grant_id_q;
   assign bus.starve_ovr = starve_ovr_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus a randomized run
// checked against a rule-level reference model.
module tb_regfile_wr_arbiter;
   localparam int NREQ  = 3;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int LIM   = 4;
   localparam int BOUND = LIM * (NREQ - 1) + NREQ;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
   regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // reference model state
   int            m_wait [NREQ];
   int            m_rr = 1;
   int            m_last_g = -1;
   logic          m_rw = 1'b0;
   logic [AW-1:0] m_rd = '0;
   logic [DW-1:0] m_data = '0;
   logic [2:0]    m_gid = 3'd0;
   logic          m_ovr = 1'b0;

   function automatic int rr_at(int k);
      return 1 + ((m_rr - 1 + k) % (NREQ - 1));
   endfunction

   function automatic int m_pick(output bit st);
      st = 1'b0;
      for (int k = 0; k < NREQ - 1; k++)
         if (bus.req_valid[rr_at(k)] && m_wait[rr_at(k)] == LIM) begin st = 1'b1; return rr_at(k); end
      if (bus.req_valid[0]) return 0;
      for (int k = 0; k < NREQ - 1; k++)
         if (bus.req_valid[rr_at(k)]) return rr_at(k);
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] m_ready();
      bit st;
      int g;
      logic [NREQ-1:0] one;
      one = 1;
      g = m_pick(st);
      if (rst || g < 0) return '0;
      return one << g;
   endfunction

   task automatic model_edge();
      bit st;
      int g;
      g = m_pick(st);
      if (rst) begin
         foreach (m_wait[i]) m_wait[i] = 0;
         m_rr = 1; m_rw = 1'b0; m_rd = '0; m_data = '0; m_gid = 3'd0; m_ovr = 1'b0;
         m_last_g = -1;
      end else begin
         for (int i = 1; i < NREQ; i++)
            m_wait[i] = (bus.req_valid[i] && i != g) ? ((m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1) : 0;
         if (g >= 0) begin
            m_rd   = bus.req_rd[g*AW +: AW];
            m_data = bus.req_data[g*DW +: DW];
            m_rw   = (m_rd != 0);
            m_gid  = 3'(g);
            m_ovr  = st && bus.req_valid[0];
            if (g >= 1) m_rr = (g == NREQ - 1) ? 1 : g + 1;
         end else begin
            m_rw = 1'b0; m_ovr = 1'b0;
         end
         m_last_g = g;
      end
   endtask

   task automatic idle(int n);
      bus.req_valid = '0;
      repeat (n) begin @(posedge clk); model_edge(); #1; end
   endtask

   task automatic test_reset();
      bus.req_valid = 3'b111;
      bus.req_rd    = {5'd3, 5'd2, 5'd1};
      bus.req_data  = {32'hC, 32'hB, 32'hA};
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
         @(posedge clk); model_edge(); #1;
         n_vec++;
         if (bus.RegWrite !== 1'b0 || bus.rd !== 5'd0 || bus.wr_data !== 32'd0 || bus.grant_id !== 3'd0 || bus.starve_ovr !== 1'b0) begin
            n_err++; $display("FAIL reset_out got rw=%b rd=%0d data=%h gid=%0d want all zero", bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL first_grant got %b want 001", bus.req_ready); end
      @(posedge clk); model_edge(); #1;
      n_vec++;
      if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd1 || bus.wr_data !== 32'hA || bus.grant_id !== 3'd0) begin
         n_err++; $display("FAIL first_write got rw=%b rd=%0d data=%h gid=%0d want 1/1/a/0", bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id);
      end
      idle(1);
   endtask

   task automatic test_single();
      bus.req_valid = 3'b010;
      bus.req_rd[AW +: AW]   = 5'd5;
      bus.req_data[DW +: DW] = 32'hDEADBEEF;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready got %b want 010", bus.req_ready); end
      @(posedge clk); model_edge(); #1;
      n_vec++;
      if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd5 || bus.wr_data !== 32'hDEADBEEF || bus.grant_id !== 3'd1 || bus.starve_ovr !== 1'b0) begin
         n_err++; $display("FAIL single_write got rw=%b rd=%0d data=%h gid=%0d want 1/5/deadbeef/1", bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id);
      end
      idle(1);
   endtask

   task automatic test_starvation();
      int gseq [6] = '{0, 0, 0, 0, 1, 0};
      logic [2:0] one;
      one = 3'b001;
      bus.req_valid = 3'b011;
      bus.req_rd[0 +: AW] = 5'd4;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus.req_ready !== (one << gseq[c])) begin n_err++; $display("FAIL starve_ready c=%0d got %b want %b", c, bus.req_ready, one << gseq[c]); end
         @(posedge clk); model_edge(); #1;
         n_vec++;
         if (bus.grant_id !== 3'(gseq[c]) || bus.starve_ovr !== (c == 4)) begin
            n_err++; $display("FAIL starve_out c=%0d got gid=%0d ovr=%b want gid=%0d ovr=%b", c, bus.grant_id, bus.starve_ovr, gseq[c], c == 4);
         end
      end
      idle(1);
   endtask

   task automatic test_round_robin();
      int exp_g;
      logic [2:0] one;
      one = 3'b001;
      exp_g = m_rr;
      bus.req_valid = 3'b110;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus.req_ready !== (one << exp_g)) begin n_err++; $display("FAIL rr_ready c=%0d got %b want %b", c, bus.req_ready, one << exp_g); end
         @(posedge clk); model_edge(); #1;
         n_vec++;
         if (bus.grant_id !== 3'(exp_g)) begin n_err++; $display("FAIL rr_gid c=%0d got %0d want %0d", c, bus.grant_id, exp_g); end
         exp_g = (exp_g == 2) ? 1 : 2;
      end
      idle(1);
   endtask

   task automatic test_x0();
      bus.req_valid = 3'b100;
      bus.req_rd[2*AW +: AW]   = 5'd0;
      bus.req_data[2*DW +: DW] = 32'h1234;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 3'b100) begin n_err++; $display("FAIL x0_ready got %b want 100", bus.req_ready); end
      @(posedge clk); model_edge(); #1;
      n_vec++;
      if (bus.RegWrite !== 1'b0 || bus.rd !== 5'd0 || bus.wr_data !== 32'h1234 || bus.grant_id !== 3'd2) begin
         n_err++; $display("FAIL x0_out got rw=%b rd=%0d data=%h gid=%0d want 0/0/1234/2", bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id);
      end
      idle(1);
   endtask

   task automatic test_mid_reset();
      bus.req_valid = 3'b010;
      bus.req_rd[AW +: AW] = 5'd7;  bus.req_data[DW +: DW]   = 32'h55;
      bus.req_rd[2*AW +: AW] = 5'd9; bus.req_data[2*DW +: DW] = 32'h99;
      @(posedge clk); model_edge(); #1;
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL midrst_ready got %b want 000", bus.req_ready); end
      @(posedge clk); model_edge(); #1;
      n_vec++;
      if (bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL midrst_rw got %b want 0", bus.RegWrite); end
      rst = 1'b0;
      bus.req_valid = 3'b110;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL midrst_reaccept got %b want 010", bus.req_ready); end
      @(posedge clk); model_edge(); #1;
      n_vec++;
      if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd7 || bus.wr_data !== 32'h55 || bus.grant_id !== 3'd1) begin
         n_err++; $display("FAIL midrst_write got rw=%b rd=%0d data=%h gid=%0d want 1/7/55/1", bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id);
      end
      idle(1);
   endtask

   task automatic test_random();
      int age [NREQ];
      foreach (age[i]) age[i] = 0;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && m_last_g != i) begin
               if ($urandom_range(0, 9) == 0) bus.req_valid[i] = 1'b0;
            end else begin
               bus.req_valid[i] = ($urandom_range(0, 1) == 1);
               bus.req_rd[i*AW +: AW]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               bus.req_data[i*DW +: DW] = $urandom;
            end
         end
         @(negedge clk);
         n_vec++;
         if (bus.req_ready !== m_ready()) begin n_err++; $display("FAIL rand_ready c=%0d got %b want %b", c, bus.req_ready, m_ready()); end
         @(posedge clk); model_edge(); #1;
         n_vec++;
         if (bus.RegWrite !== m_rw || bus.rd !== m_rd || bus.wr_data !== m_data || bus.grant_id !== m_gid || bus.starve_ovr !== m_ovr) begin
            n_err++;
            $display("FAIL rand_out c=%0d got rw=%b rd=%0d data=%h gid=%0d ovr=%b want rw=%b rd=%0d data=%h gid=%0d ovr=%b",
                     c, bus.RegWrite, bus.rd, bus.wr_data, bus.grant_id, bus.starve_ovr, m_rw, m_rd, m_data, m_gid, m_ovr);
         end
         for (int i = 0; i < NREQ; i++)
            age[i] = (!rst && bus.req_valid[i] && m_last_g != i) ? age[i] + 1 : 0;
         n_vec++;
         for (int i = 0; i < NREQ; i++)
            if (age[i] > BOUND) begin n_err++; $display("FAIL rand_wait src=%0d got %0d want <= %0d", i, age[i], BOUND); end
      end
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      foreach (m_wait[i]) m_wait[i] = 0;
      bus.req_valid = '0;
      bus.req_rd    = '0;
      bus.req_data  = '0;
      test_reset();
      test_single();
      test_starvation();
      test_round_robin();
      test_x0();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
